// File: rtl/seg7_scan_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : seg7_scan_ctrl
// Function : Round-robin refresh of eight active-low 7-segment displays from
//            eight 4-bit digit registers through one shared decoder.
//            Optional build macro SEG7_HEX_AF_EN: values 10-15 show A,b,C,d,E,F.
// Revision : 1.0
// ============================================================================
module seg7_scan_ctrl #(
   parameter int REFRESH_DIV = 50000
) (
   input  logic       CLOCK_50,
   input  logic       rst_n,
   input  logic       wr_en,
   input  logic [2:0] wr_addr,
   input  logic [3:0] wr_data,
   input  logic [7:0] blank,
   input  logic       restart,
   output logic       scan_done,
   output logic [6:0] HEX0,
   output logic [6:0] HEX1,
   output logic [6:0] HEX2,
   output logic [6:0] HEX3,
   output logic [6:0] HEX4,
   output logic [6:0] HEX5,
   output logic [6:0] HEX6,
   output logic [6:0] HEX7
);

   localparam int              C_CW    = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
   localparam logic [C_CW-1:0] C_LAST  = C_CW'(REFRESH_DIV - 1);
   localparam logic [6:0]      C_BLANK = 7'b1111111;

   logic [C_CW-1:0] presc_q, presc_d;
   logic [2:0]      ptr_q, ptr_d;
   logic            scan_done_q, scan_done_d;
   logic [3:0]      digit_q [8];
   logic [55:0]     hex_bus;
   logic            tick;
   logic            update;
   logic [6:0]      seg_d;

   function automatic logic [6:0] decode(input logic [3:0] val);
      logic [6:0] seg;
      case (val)
         4'd0:    seg = 7'b1000000;
         4'd1:    seg = 7'b1111001;
         4'd2:    seg = 7'b0100100;
         4'd3:    seg = 7'b0110000;
         4'd4:    seg = 7'b0011001;
         4'd5:    seg = 7'b0010010;
         4'd6:    seg = 7'b0000010;
         4'd7:    seg = 7'b1111000;
         4'd8:    seg = 7'b0000000;
         4'd9:    seg = 7'b0010000;
`ifdef SEG7_HEX_AF_EN
         4'd10:   seg = 7'b0001000;
         4'd11:   seg = 7'b0000011;
         4'd12:   seg = 7'b1000110;
         4'd13:   seg = 7'b0100001;
         4'd14:   seg = 7'b0000110;
         4'd15:   seg = 7'b0001110;
`endif
         default: seg = C_BLANK;
      endcase
      return seg;
   endfunction

   // restart overrides a coincident tick: no display update, no frame pulse
   always_comb begin
      tick        = (presc_q == C_LAST);
      update      = tick & ~restart;
      presc_d     = (restart | tick) ? '0 : presc_q + C_CW'(1);
      ptr_d       = restart ? 3'd0 : (update ? ptr_q + 3'd1 : ptr_q);
      scan_done_d = update & (ptr_q == 3'd7);
      seg_d       = blank[ptr_q] ? C_BLANK : decode(digit_q[ptr_q]);
   end

   always_ff @(posedge CLOCK_50 or negedge rst_n) begin
      if (!rst_n) begin
         presc_q     <= '0;
         ptr_q       <= 3'd0;
         scan_done_q <= 1'b0;
      end else begin
         presc_q     <= presc_d;
         ptr_q       <= ptr_d;
         scan_done_q <= scan_done_d;
      end
   end

   // The scan reads digit_q before this edge, so a same-cycle write shows next pass
   always_ff @(posedge CLOCK_50 or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < 8; i++) begin
            digit_q[i] <= 4'd0;
         end
      end else if (wr_en) begin
         digit_q[wr_addr] <= wr_data;
      end
   end

   generate
      for (genvar k = 0; k < 8; k++) begin : g_hex
         logic [6:0] hex_q;

         always_ff @(posedge CLOCK_50 or negedge rst_n) begin
            if (!rst_n) begin
               hex_q <= C_BLANK;
            end else if (update && (ptr_q == 3'(k))) begin
               hex_q <= seg_d;
            end
         end

         assign hex_bus[k*7 +: 7] = hex_q;
      end
   endgenerate

   assign scan_done = scan_done_q;
   assign HEX0      = hex_bus[6:0];
   assign HEX1      = hex_bus[13:7];
   assign HEX2      = hex_bus[20:14];
   assign HEX3      = hex_bus[27:21];
   assign HEX4      = hex_bus[34:28];
   assign HEX5      = hex_bus[41:35];
   assign HEX6      = hex_bus[48:42];
   assign HEX7      = hex_bus[55:49];

endmodule
`default_nettype wire

// File: tb/tb_seg7_scan_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_seg7_scan_ctrl
// Function : Directed scoreboard bench for seg7_scan_ctrl with REFRESH_DIV=4.
// Revision : 1.0
// ============================================================================
module tb_seg7_scan_ctrl;

   localparam int DIV = 4;

   typedef struct {
      int         e;
      int         idx;
      logic [6:0] v;
   } exp_t;

   logic       clk     = 1'b0;
   logic       rst_n   = 1'b0;
   logic       wr_en   = 1'b0;
   logic [2:0] wr_addr = 3'd0;
   logic [3:0] wr_data = 4'd0;
   logic [7:0] blank   = 8'h00;
   logic       restart = 1'b0;
   logic       scan_done;
   logic [6:0] hex [8];

   int   ec     = 0;
   int   checks = 0;
   int   errors = 0;
   exp_t sb[$];
   exp_t mon_it;
   int   r0;
   int   r2;

   seg7_scan_ctrl #(.REFRESH_DIV(DIV)) dut (
      .CLOCK_50  (clk),
      .rst_n     (rst_n),
      .wr_en     (wr_en),
      .wr_addr   (wr_addr),
      .wr_data   (wr_data),
      .blank     (blank),
      .restart   (restart),
      .scan_done (scan_done),
      .HEX0      (hex[0]),
      .HEX1      (hex[1]),
      .HEX2      (hex[2]),
      .HEX3      (hex[3]),
      .HEX4      (hex[4]),
      .HEX5      (hex[5]),
      .HEX6      (hex[6]),
      .HEX7      (hex[7])
   );

   always #5 clk = ~clk;

   always @(posedge clk) ec <= ec + 1;

   task automatic check(input string nm, input logic [6:0] act, input logic [6:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: got %b expected %b", nm, act, req);
      end
   endtask

   // Insert keeping the queue ordered by target edge
   task automatic exp_at(input int e, input int idx, input logic [6:0] v);
      exp_t it;
      int   pos;
      it.e   = e;
      it.idx = idx;
      it.v   = v;
      pos    = sb.size();
      for (int i = sb.size() - 1; i >= 0; i--) begin
         if (sb[i].e > e) pos = i;
      end
      sb.insert(pos, it);
   endtask

   task automatic goto(input int n);
      while (ec < n) @(negedge clk);
   endtask

   task automatic wr(input int a, input int d);
      wr_en   = 1'b1;
      wr_addr = 3'(a);
      wr_data = 4'(d);
   endtask

   always @(negedge clk) begin
      while (sb.size() > 0 && sb[0].e <= ec) begin
         mon_it = sb.pop_front();
         if (mon_it.e < ec) begin
            checks++;
            errors++;
            $display("FAIL late_check idx=%0d edge=%0d: checked at %0d", mon_it.idx, mon_it.e, ec);
         end else if (mon_it.idx == 8) begin
            check($sformatf("scan_done@%0d", mon_it.e), {6'b0, scan_done}, mon_it.v);
         end else begin
            check($sformatf("HEX%0d@%0d", mon_it.idx, mon_it.e), hex[mon_it.idx], mon_it.v);
         end
      end
   end

   initial begin
      #50000;
      $display("FAIL watchdog: run did not end, errors=%0d checks=%0d", errors, checks);
      $fatal(1);
   end

   initial begin
      // Reset and first frame
      for (int k = 0; k < 8; k++) begin
         exp_at(2, k, 7'b1111111);
         exp_at(3, k, 7'b1111111);
      end
      exp_at(3, 8, 7'd0);
      goto(4);
      rst_n = 1'b1;
      r0    = ec;
      exp_at(r0 + 3,  0, 7'b1111111);
      exp_at(r0 + 4,  0, 7'b1000000);
      exp_at(r0 + 31, 7, 7'b1111111);
      exp_at(r0 + 32, 7, 7'b1000000);
      exp_at(r0 + 31, 8, 7'd0);
      exp_at(r0 + 32, 8, 7'd1);
      exp_at(r0 + 33, 8, 7'd0);

      // Digits 1..8 written just ahead of the second frame
      exp_at(r0 + 35, 0, 7'b1000000);
      exp_at(r0 + 36, 0, 7'b1111001);
      exp_at(r0 + 40, 1, 7'b0100100);
      exp_at(r0 + 44, 2, 7'b0110000);
      exp_at(r0 + 48, 3, 7'b0011001);
      exp_at(r0 + 52, 4, 7'b0010010);
      exp_at(r0 + 56, 5, 7'b0000010);
      exp_at(r0 + 60, 6, 7'b1111000);
      exp_at(r0 + 64, 7, 7'b0000000);
      for (int k = 0; k < 8; k++) begin
         goto(r0 + 32 + k);
         wr(k, k + 1);
      end
      goto(r0 + 40);
      wr_en = 1'b0;

      // Write digit 3 on the very edge HEX3 refreshes
      exp_at(r0 + 80,  3, 7'b0011001);
      exp_at(r0 + 111, 3, 7'b0011001);
      exp_at(r0 + 112, 3, 7'b0010000);
      goto(r0 + 79);
      wr(3, 9);
      goto(r0 + 80);
      wr_en = 1'b0;

      // All digits 5 with HEX0/HEX7 blanked
      exp_at(r0 + 132, 0, 7'b1111111);
      for (int k = 1; k < 7; k++) exp_at(r0 + 132 + 4 * k, k, 7'b0010010);
      exp_at(r0 + 160, 7, 7'b1111111);
      goto(r0 + 112);
      blank = 8'h81;
      for (int k = 0; k < 8; k++) begin
         goto(r0 + 112 + k);
         wr(k, 5);
      end
      goto(r0 + 120);
      wr_en = 1'b0;

      // Restart while ptr = 5
      exp_at(r0 + 164, 0, 7'b0010010);
      exp_at(r0 + 184, 5, 7'b0010010);
      exp_at(r0 + 185, 0, 7'b0010010);
      exp_at(r0 + 186, 0, 7'b1000000);
      exp_at(r0 + 192, 8, 7'd0);
      exp_at(r0 + 193, 8, 7'd0);
      exp_at(r0 + 205, 5, 7'b0010010);
      exp_at(r0 + 206, 5, 7'b0100100);
      exp_at(r0 + 213, 8, 7'd0);
      exp_at(r0 + 214, 8, 7'd1);
      exp_at(r0 + 215, 8, 7'd0);
      goto(r0 + 160);
      blank = 8'h00;
      goto(r0 + 161);
      wr(5, 2);
      goto(r0 + 162);
      wr_en = 1'b0;
      goto(r0 + 181);
      restart = 1'b1;
      goto(r0 + 182);
      restart = 1'b0;
      wr(0, 0);
      goto(r0 + 183);
      wr_en = 1'b0;

      // Restart on the same edge as a tick
      exp_at(r0 + 218, 0, 7'b1000000);
      exp_at(r0 + 221, 0, 7'b1000000);
      exp_at(r0 + 222, 0, 7'b1111000);
      goto(r0 + 214);
      wr(0, 7);
      goto(r0 + 215);
      wr_en = 1'b0;
      goto(r0 + 217);
      restart = 1'b1;
      goto(r0 + 218);
      restart = 1'b0;

      // Value 12 on digit 2
      exp_at(r0 + 229, 2, 7'b0010010);
`ifdef SEG7_HEX_AF_EN
      exp_at(r0 + 230, 2, 7'b1000110);
`else
      exp_at(r0 + 230, 2, 7'b1111111);
`endif
      goto(r0 + 222);
      wr(2, 12);
      goto(r0 + 223);
      wr_en = 1'b0;

      // Asynchronous reset mid-frame
      goto(r0 + 232);
      #2;
      rst_n = 1'b0;
      #1;
      for (int k = 0; k < 8; k++) check($sformatf("async_rst_HEX%0d", k), hex[k], 7'b1111111);
      check("async_rst_scan_done", {6'b0, scan_done}, 7'd0);
      goto(ec + 2);
      rst_n = 1'b1;
      r2    = ec;
      exp_at(r2 + 3,  0, 7'b1111111);
      exp_at(r2 + 4,  0, 7'b1000000);
      exp_at(r2 + 12, 2, 7'b1000000);
      goto(r2 + 14);

      if (sb.size() != 0) begin
         checks += sb.size();
         errors += sb.size();
         $display("FAIL scoreboard_drain: %0d pending expected 0", sb.size());
      end
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
`default_nettype wire
